// File: rtl/rf_write_arbiter_if.sv
// Handshake bundle between decode/writeback sources and the register-file write arbiter.
// Carries the claim/hazard query, both writeback requests, and the registered write port.
// The slave modport is the arbiter itself; the master modport is whatever drives it.
interface rf_write_arbiter_if #(
  parameter int DATA_W = 24,
  parameter int REG_W  = 3
);
  localparam int NREGS = 2 ** REG_W;

  // decode side: destination claim and source hazard query
  logic              claim_valid;
  logic [REG_W-1:0]  claim_reg;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic              stall;

  // writeback requester 0 (ALU)
  logic              req0_valid;
  logic [REG_W-1:0]  req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  // writeback requester 1 (memory load)
  logic              req1_valid;
  logic [REG_W-1:0]  req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  // registered register-file write port and scoreboard
  logic              RegWrite;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] Wdata;
  logic [NREGS-1:0]  busy;

  modport slave (
    input  claim_valid, claim_reg, rs1, rs2,
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output stall, req0_ready, req1_ready,
    output RegWrite, WriteReg, Wdata, busy
  );

  modport master (
    output claim_valid, claim_reg, rs1, rs2,
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  stall, req0_ready, req1_ready,
    input  RegWrite, WriteReg, Wdata, busy
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback, plus a busy scoreboard.
// Latency: grant is combinational (0 cycles); accepted write appears on RegWrite/WriteReg/Wdata one cycle later.
// Backpressure: the losing requester sees ready low and must hold; one write accepted per cycle.
module rf_write_arbiter #(
  parameter int DATA_W = 24,
  parameter int REG_W  = 3
) (
  input logic                 clk,
  input logic                 reset,
  rf_write_arbiter_if.slave   bus
);
  localparam int NREGS = 2 ** REG_W;

  // round-robin pointer: which requester wins when both are valid
  logic              r_pri;
  // registered write stage driving the register file
  logic              r_regwrite;
  logic [REG_W-1:0]  r_writereg;
  logic [DATA_W-1:0] r_wdata;
  // outstanding-producer scoreboard; bit 0 never set
  logic [NREGS-1:0]  r_busy;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_xfer;
  logic [REG_W-1:0]  w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_is_r0;
  logic              w_claim_set;
  logic [NREGS-1:0]  w_busy_nxt;

  // A lone valid always wins; on contention the pointer picks the winner.
  always_comb begin
    w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_pri);
    w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_pri);
  end

  // Mux the winning request onto the write path.
  always_comb begin
    w_xfer      = w_grant0 | w_grant1;
    w_sel_reg   = w_grant0 ? bus.req0_reg  : bus.req1_reg;
    w_sel_data  = w_grant0 ? bus.req0_data : bus.req1_data;
    w_sel_is_r0 = (w_sel_reg == '0);
  end

  // Next scoreboard: clear the retiring destination, then apply the claim so a new producer wins.
  always_comb begin
    w_claim_set = bus.claim_valid & (bus.claim_reg != '0);
    w_busy_nxt  = r_busy;
    if (w_xfer) begin
      w_busy_nxt[w_sel_reg] = 1'b0;
    end
    if (w_claim_set) begin
      w_busy_nxt[bus.claim_reg] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Pointer flips to the other requester after each transfer, including dropped reg-0 writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pri <= 1'b0;
    end else if (w_xfer) begin
      r_pri <= w_grant0;
    end
  end

  // Write stage: enable pulses for one cycle per transfer; index/data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_writereg <= '0;
      r_wdata    <= '0;
    end else begin
      r_regwrite <= w_xfer & ~w_sel_is_r0;
      if (w_xfer && !w_sel_is_r0) begin
        r_writereg <= w_sel_reg;
        r_wdata    <= w_sel_data;
      end
    end
  end

  // Scoreboard state update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Outputs: grants and hazard are combinational, write port and busy come from registers.
  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.stall      = r_busy[bus.rs1] | r_busy[bus.rs2];
  assign bus.RegWrite   = r_regwrite;
  assign bus.WriteReg   = r_writereg;
  assign bus.Wdata      = r_wdata;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized and directed bench for rf_write_arbiter against a behavioural reference model.
// Inputs change on the falling edge; combinational outputs checked before the rising edge, registered ones just after.
// The model keeps the priority, scoreboard set and expected write port as plain variables.
module tb_rf_write_arbiter;
  logic clk;
  logic reset;

  rf_write_arbiter_if #(.DATA_W(24), .REG_W(3)) bus ();

  rf_write_arbiter #(.DATA_W(24), .REG_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int        m_pri;
  bit [7:0]  m_busy;
  bit        m_we;
  bit [2:0]  m_wr;
  bit [23:0] m_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pri  = 0;
    m_busy = '0;
    m_we   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  task automatic drive_idle();
    bus.claim_valid = 1'b0; bus.claim_reg = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
  endtask

  // One clock cycle: drive, check grants/stall, clock, update model, check registered outputs.
  task automatic step(input logic cv, input logic [2:0] creg,
                      input logic [2:0] r1, input logic [2:0] r2,
                      input logic v0, input logic [2:0] g0reg, input logic [23:0] d0,
                      input logic v1, input logic [2:0] g1reg, input logic [23:0] d1,
                      output logic o_rdy0, output logic o_rdy1, output logic o_stall);
    bit win0, win1;
    bit [2:0] dst;
    @(negedge clk);
    bus.claim_valid = cv; bus.claim_reg = creg;
    bus.rs1 = r1; bus.rs2 = r2;
    bus.req0_valid = v0; bus.req0_reg = g0reg; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_reg = g1reg; bus.req1_data = d1;
    // the winner: a lone requester, or the one the pointer names
    win0 = 1'b0; win1 = 1'b0;
    if (v0 && v1) begin
      if (m_pri == 0) win0 = 1'b1; else win1 = 1'b1;
    end else if (v0) begin
      win0 = 1'b1;
    end else if (v1) begin
      win1 = 1'b1;
    end
    #1;
    o_rdy0  = bus.req0_ready;
    o_rdy1  = bus.req1_ready;
    o_stall = bus.stall;
    check("req0_ready", 32'(bus.req0_ready), 32'(win0));
    check("req1_ready", 32'(bus.req1_ready), 32'(win1));
    check("stall", 32'(bus.stall), 32'(m_busy[r1] | m_busy[r2]));
    @(posedge clk);
    m_we = 1'b0;
    if (win0 || win1) begin
      dst   = win0 ? g0reg : g1reg;
      m_pri = win0 ? 1 : 0;
      m_busy[dst] = 1'b0;
      if (dst != 0) begin
        m_we = 1'b1;
        m_wr = dst;
        m_wd = win0 ? d0 : d1;
      end
    end
    if (cv && creg != 0) m_busy[creg] = 1'b1;
    #1;
    check("RegWrite", 32'(bus.RegWrite), 32'(m_we));
    check("WriteReg", 32'(bus.WriteReg), 32'(m_wr));
    check("Wdata",    32'(bus.Wdata),    32'(m_wd));
    check("busy",     32'(bus.busy),     32'(m_busy));
  endtask

  logic rd0, rd1, st;

  initial begin
    drive_idle();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'h00);
    @(negedge clk);
    reset = 1'b0;

    // idle after reset: nothing granted, nothing busy
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
      check("idle_ready0", 32'(rd0), 32'd0);
      check("idle_ready1", 32'(rd1), 32'd0);
      check("idle_stall",  32'(st),  32'd0);
    end

    // contention: both valid, grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 3'd1, 24'h000100 + 24'(i), 1, 3'd2, 24'h000200 + 24'(i), rd0, rd1, st);
      check("rr_ready0", 32'(rd0), 32'((i % 2) == 0));
      check("rr_ready1", 32'(rd1), 32'((i % 2) == 1));
      check("rr_WriteReg", 32'(bus.WriteReg), ((i % 2) == 0) ? 32'd1 : 32'd2);
    end

    // single requester write to reg 3
    step(0, 0, 0, 0, 1, 3'd3, 24'h00ABCD, 0, 0, 0, rd0, rd1, st);
    check("single_ready0", 32'(rd0), 32'd1);
    check("single_RegWrite", 32'(bus.RegWrite), 32'd1);
    check("single_WriteReg", 32'(bus.WriteReg), 32'd3);
    check("single_Wdata", 32'(bus.Wdata), 32'h00ABCD);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
    check("single_RegWrite_off", 32'(bus.RegWrite), 32'd0);

    // scoreboard hazard on reg 5, cleared by a load writeback
    step(1, 3'd5, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
    check("haz_busy", 32'(bus.busy), 32'h20);
    step(0, 0, 3'd5, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
    check("haz_stall", 32'(st), 32'd1);
    step(0, 0, 3'd5, 0, 0, 0, 0, 1, 3'd5, 24'h0055AA, rd0, rd1, st);
    check("haz_busy5_clr", 32'(bus.busy[5]), 32'd0);
    step(0, 0, 3'd5, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
    check("haz_stall_clr", 32'(st), 32'd0);

    // simultaneous claim and clear of reg 4: the claim wins
    step(1, 3'd4, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1, st);
    step(1, 3'd4, 0, 0, 1, 3'd4, 24'h004444, 0, 0, 0, rd0, rd1, st);
    check("sim_busy4", 32'(bus.busy[4]), 32'd1);
    check("sim_RegWrite", 32'(bus.RegWrite), 32'd1);
    check("sim_WriteReg", 32'(bus.WriteReg), 32'd4);
    // retire reg 4 so later state is clean
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'd4, 24'h000444, rd0, rd1, st);

    // write to reg 0: consumed, dropped, pointer still advances
    step(0, 0, 0, 0, 1, 3'd0, 24'h123456, 0, 0, 0, rd0, rd1, st);
    check("r0_ready0", 32'(rd0), 32'd1);
    check("r0_RegWrite", 32'(bus.RegWrite), 32'd0);
    step(0, 0, 0, 0, 1, 3'd6, 24'h000006, 1, 3'd7, 24'h000007, rd0, rd1, st);
    check("r0_pri_ready1", 32'(rd1), 32'd1);

    // reset between edges while a write is in flight
    step(1, 3'd2, 0, 0, 1, 3'd6, 24'h0A0A0A, 0, 0, 0, rd0, rd1, st);
    check("pre_rst_RegWrite", 32'(bus.RegWrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("arst_busy",     32'(bus.busy),     32'h00);
    check("arst_WriteReg", 32'(bus.WriteReg), 32'd0);
    check("arst_Wdata",    32'(bus.Wdata),    32'd0);
    bus.req1_valid = 1'b1; bus.req1_reg = 3'd3; bus.claim_valid = 1'b1; bus.claim_reg = 3'd3;
    #1;
    check("arst_pri_ready0", 32'(bus.req0_ready), 32'd1);
    check("arst_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_busy", 32'(bus.busy), 32'h00);
    check("arst_hold_RegWrite", 32'(bus.RegWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    model_reset();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 24'($urandom),
           1'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 24'($urandom),
           rd0, rd1, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter and destination scoreboard for the 8 x 24-bit register file. It shares the register file's single write port between two writeback requesters: requester 0 is the ALU and requester 1 is memory load. It drives the register file's RegWrite/WriteReg/Wdata inputs from a registered stage. It also tracks which registers have an outstanding producer, so decode can stall on read-after-write hazards.

## Interface
Parameters:
- DATA_W, 24, data width; matches register file word.
- REG_W, 3, register index width; NREGS = 2**REG_W = 8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- claim_valid  input  1  decode issues an instruction that will write claim_reg.
- claim_reg  input  REG_W  destination being claimed.
- rs1, rs2  input  REG_W  decode source registers for hazard query.
- stall  output  1  combinational: busy[rs1] | busy[rs2].
- req0_valid, req1_valid  input  1  writeback request present.
- req0_reg, req1_reg  input  REG_W  destination index.
- req0_data, req1_data  input  DATA_W  writeback value.
- req0_ready, req1_ready  output  1  combinational grant; transfer occurs when valid & ready on a clock edge.
- RegWrite  output  1  registered write enable to register file.
- WriteReg  output  REG_W  registered write index.
- Wdata  output  DATA_W  registered write data.
- busy  output  NREGS  registered scoreboard vector.

## Operation
- Arbitration: round-robin with a 1-bit priority pointer `pri`, reset 0.
  - Only one valid: that requester is granted.
  - Both valid: requester `pri` is granted.
  - After any transfer to requester i, `pri` becomes 1-i. With no transfer, `pri` holds.
  - At most one ready is high per cycle. Ready is never high without its valid.
- Write stage: on a transfer, register {RegWrite=1, WriteReg=req_reg, Wdata=req_data} for the next cycle. With no transfer, RegWrite=0. WriteReg and Wdata hold their previous values when RegWrite=0.
- Register 0: a request to reg 0 is still granted and consumed, but RegWrite is registered 0 (write dropped) and `pri` still advances.
- Scoreboard (busy[0] is hard-wired 0):
  - Set: claim_valid with claim_reg != 0 sets busy[claim_reg] at the edge.
  - Clear: a transfer with req_reg = r clears busy[r] at the same edge the write stage is loaded.
  - Simultaneous set and clear of the same register: set wins, because the new producer supersedes.
  - Set and clear of different registers in one cycle both take effect.
  - A clear of a non-busy register is harmless.
- stall is purely combinational from the current busy and rs1/rs2. rs = 0 never stalls.

## Timing
- Grant latency 0: ready is asserted in the same cycle as valid when granted.
- Write latency: data accepted at edge N appears on RegWrite/WriteReg/Wdata during cycle N+1. The register file captures it at edge N+1.
- Scoreboard clear happens at edge N, one cycle before the register file holds the data. Decode must therefore also use a bypass path or tolerate one cycle; this block provides no forwarding.
- Throughput: one write per cycle. Continuous requests from both requesters alternate 0,1,0,1…
- Reset (asynchronous, any time including mid-transfer):
  - RegWrite=0, WriteReg=0, Wdata=0, busy=0, pri=0.
  - The in-flight registered write is discarded.
  - Ready outputs follow valids combinationally, but no state changes while reset is high.

## Test plan
- Reset then idle: after reset, RegWrite=0, busy=8'h00, stall=0, both ready=0 → held indefinitely with no valids.
- Single requester: req0_valid=1, reg=3, data=24'h00ABCD for one cycle → req0_ready=1 that cycle; next cycle RegWrite=1, WriteReg=3, Wdata=24'h00ABCD; the cycle after, RegWrite=0.
- Contention round-robin: both valid continuously for 4 cycles (req0 reg 1, req1 reg 2) → grants 0,1,0,1. WriteReg sequence 1,2,1,2, one cycle delayed.
- Scoreboard hazard: claim reg 5; next cycle rs1=5 → busy=8'h20, stall=1. Then req1 writes reg 5 → busy[5]=0 after that edge, and stall=0 with rs1=5.
- Simultaneous claim/clear: reg 4 busy; in one cycle claim_reg=4 and req0 writes reg 4 → busy[4] remains 1, and RegWrite=1 with WriteReg=4 next cycle.
- Reg 0 and reset mid-op: req0 writes reg 0 → ready=1, next cycle RegWrite=0, pri=1. Then assert reset asynchronously between edges while RegWrite=1 → RegWrite, busy and pri drop to 0 immediately, before the next edge.
